// File: rtl/lsu_align_if.sv
// lsu_align_if: core request/response and data-memory port bundle for lsu_align.
interface lsu_align_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd;
    logic [3:0]  mem_we;
    logic [2:0]  mem_load_select;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_rd, mem_we, mem_load_select, mem_addr, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_rd, mem_we, mem_load_select, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit; splits misaligned accesses into two word accesses.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses instead of rejecting them.
module lsu_align #(
    parameter int IO_SEL_BIT = 20
) (
    input logic        clk,
    input logic        rst,
    lsu_align_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
    state_t      state, state_nx;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, lo_q;
    logic        accept, bad_f3, mis, reject, split, split_ok;
    logic [3:0]  m4;
    logic [7:0]  mask;
    logic [31:0] wa, ld_sh, ext;
    logic [63:0] wsh;

    function automatic logic [2:0] span(input logic [1:0] sz, input logic [1:0] o);
        return {1'b0, o} + (sz == 2'b00 ? 3'd1 : sz == 2'b01 ? 3'd2 : 3'd4);
    endfunction

    assign accept = bus.req_valid & bus.req_ready;
    assign bad_f3 = (bus.req_funct3[1:0] == 2'b11) | (bus.req_funct3[2] & bus.req_funct3[1])
                  | (bus.req_we & bus.req_funct3[2]);
    assign mis    = span(bus.req_funct3[1:0], bus.req_addr[1:0]) > 3'd4;
    assign split  = span(f3_q[1:0], addr_q[1:0]) > 3'd4;
`ifdef LSU_MISALIGN_SPLIT_EN
    // The ROM/IO region cannot tolerate the two-access split.
    assign reject   = bad_f3 | (mis & bus.req_addr[IO_SEL_BIT]);
    assign split_ok = split;
`else
    assign reject   = bad_f3 | mis;
    assign split_ok = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            lo_q    <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                err_q   <= reject;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == ACC1)
                lo_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_nx = state == IDLE ? (accept ? (reject ? RESP : ACC0) : IDLE)
                 : state == ACC0 ? (split_ok ? ACC1 : RESP)
                 : state == ACC1 ? RESP : IDLE;
    end

    always_comb begin
        wa    = {addr_q[31:2], 2'b00};
        m4    = f3_q[1:0] == 2'b00 ? 4'b0001 : f3_q[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
        mask  = {4'b0000, m4} << addr_q[1:0];
        wsh   = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
        // Second word (if any) is on mem_rdata in RESP; the first was parked in lo_q.
        ld_sh = 32'({split ? bus.mem_rdata : 32'h0, split ? lo_q : bus.mem_rdata} >> {addr_q[1:0], 3'b000});
        ext   = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & ld_sh[7]}}, ld_sh[7:0]}
              : f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & ld_sh[15]}}, ld_sh[15:0]} : ld_sh;
        bus.req_ready       = (state == IDLE) & ~rst;
        bus.mem_load_select = 3'b010;
        bus.mem_rd          = (state == ACC0) | (state == ACC1);
        bus.mem_addr        = state == ACC0 ? wa : state == ACC1 ? wa + 32'd4 : 32'h0;
        bus.mem_we          = ~we_q ? 4'b0000 : state == ACC0 ? mask[3:0] : state == ACC1 ? mask[7:4] : 4'b0000;
        bus.mem_wdata       = ~we_q ? 32'h0 : state == ACC0 ? wsh[31:0] : state == ACC1 ? wsh[63:32] : 32'h0;
        bus.resp_valid      = state == RESP;
        bus.resp_err        = (state == RESP) & err_q;
        bus.resp_rdata      = (state == RESP) & ~we_q & ~err_q ? ext : 32'h0;
    end
endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: directed self-checking bench for lsu_align; outputs sampled on the falling edge.
module tb_lsu_align;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lsu_align_if bus();
    lsu_align dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge of cycle T+1 (the cycle after acceptance).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        chk("ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] word, input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        chk({tag, "_rd"}, 32'(bus.mem_rd), 32'd1);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
        bus.mem_rdata = word;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_data"}, bus.resp_rdata, exp);
    endtask

    task automatic err_req(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a);
        issue(we, f3, a, 32'h1234_5678);
        chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_err"}, 32'(bus.resp_err), 32'd1);
        chk({tag, "_rd"}, 32'(bus.mem_rd), 32'd0);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        chk({tag, "_single"}, 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic sw_10(input string tag);
        issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
        chk({tag, "_rd"}, 32'(bus.mem_rd), 32'd1);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'hF);
        chk({tag, "_addr"}, bus.mem_addr, 32'h10);
        chk({tag, "_wdata"}, bus.mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_err"}, 32'(bus.resp_err), 32'd0);
        chk({tag, "_rd_off"}, 32'(bus.mem_rd), 32'd0);
        chk({tag, "_we_off"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_rdata0"}, bus.resp_rdata, 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_rdata  = 32'h0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_err", 32'(bus.resp_err), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("load_sel", 32'(bus.mem_load_select), 32'd2);
        rst = 1'b0;

        sw_10("sw");
        @(negedge clk);
        chk("idle_after_sw", 32'(bus.resp_valid), 32'd0);

        load("lb", 3'b000, 32'h0000_0013, 32'h80FF_1234, 32'hFFFF_FF80);
        load("lbu", 3'b100, 32'h0000_0013, 32'h80FF_1234, 32'h0000_0080);
        load("lb0", 3'b000, 32'h0000_0010, 32'h80FF_1234, 32'h0000_0034);
        load("lh", 3'b001, 32'h0000_0012, 32'h80FF_1234, 32'hFFFF_80FF);
        load("lhu", 3'b101, 32'h0000_0012, 32'h80FF_1234, 32'h0000_80FF);
        load("lw", 3'b010, 32'h0000_0010, 32'h80FF_1234, 32'h80FF_1234);

        issue(1'b1, 3'b001, 32'h0000_0022, 32'h0000_A55A);
        chk("sh_we", 32'(bus.mem_we), 32'hC);
        chk("sh_addr", bus.mem_addr, 32'h20);
        chk("sh_wdata", bus.mem_wdata, 32'hA55A_0000);
        @(negedge clk);
        chk("sh_valid", 32'(bus.resp_valid), 32'd1);
        chk("sh_rd_off", 32'(bus.mem_rd), 32'd0);

        issue(1'b1, 3'b000, 32'h0000_0041, 32'h0000_00A7);
        chk("sb_we", 32'(bus.mem_we), 32'h2);
        chk("sb_wdata", bus.mem_wdata, 32'h0000_A700);
        @(negedge clk);

        err_req("f3_011", 1'b0, 3'b011, 32'h0);
        err_req("f3_110", 1'b0, 3'b110, 32'h0);
        err_req("st_bu", 1'b1, 3'b100, 32'h0);

`ifdef LSU_MISALIGN_SPLIT_EN
        issue(1'b0, 3'b010, 32'h0000_0006, 32'h0);
        chk("lw_s_addr0", bus.mem_addr, 32'h04);
        chk("lw_s_rd0", 32'(bus.mem_rd), 32'd1);
        bus.mem_rdata = 32'h4433_2211;
        @(negedge clk);
        chk("lw_s_addr1", bus.mem_addr, 32'h08);
        chk("lw_s_rd1", 32'(bus.mem_rd), 32'd1);
        chk("lw_s_early", 32'(bus.resp_valid), 32'd0);
        bus.mem_rdata = 32'h8877_6655;
        @(negedge clk);
        chk("lw_s_valid", 32'(bus.resp_valid), 32'd1);
        chk("lw_s_data", bus.resp_rdata, 32'h6655_4433);

        issue(1'b1, 3'b010, 32'h0000_0007, 32'hCAFE_BABE);
        chk("sw_s_we0", 32'(bus.mem_we), 32'h8);
        chk("sw_s_wd0", bus.mem_wdata, 32'hBE00_0000);
        @(negedge clk);
        chk("sw_s_we1", 32'(bus.mem_we), 32'h7);
        chk("sw_s_wd1", bus.mem_wdata, 32'h00CA_FEBA);
        chk("sw_s_addr1", bus.mem_addr, 32'h08);
        @(negedge clk);
        chk("sw_s_valid", 32'(bus.resp_valid), 32'd1);
        chk("sw_s_err", 32'(bus.resp_err), 32'd0);

        err_req("io_mis", 1'b0, 3'b001, 32'h0010_0003);

        issue(1'b1, 3'b010, 32'h0000_0007, 32'hCAFE_BABE);
        @(negedge clk);
        chk("abort_we_pre", 32'(bus.mem_we), 32'h7);
        rst = 1'b1;
        #1;
        chk("abort_we", 32'(bus.mem_we), 32'd0);
        chk("abort_rd", 32'(bus.mem_rd), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("abort_noresp", 32'(bus.resp_valid), 32'd0);
        rst = 1'b0;
`else
        err_req("lh_mis", 1'b0, 3'b001, 32'h0000_0003);
        err_req("lw_mis", 1'b0, 3'b010, 32'h0000_0006);

        issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("abort_we_pre", 32'(bus.mem_we), 32'hF);
        rst = 1'b1;
        #1;
        chk("abort_we", 32'(bus.mem_we), 32'd0);
        chk("abort_rd", 32'(bus.mem_rd), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("abort_noresp", 32'(bus.resp_valid), 32'd0);
        rst = 1'b0;
`endif
        sw_10("sw_after_rst");
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit directly upstream of the data memory block.
- Accepts one core load/store request at a time and drives the memory port: read strobe, byte write enables, word address, lane-shifted write data.
- Splits misaligned accesses into two word accesses, merges the read data, and sign/zero-extends the loaded value.
- Always drives memory load-select as raw word (3'b010); all extension happens here.

Parameters:
- IO_SEL_BIT, 20: address bit selecting the ROM/IO region; a misaligned access with this bit set always errors.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; valid only while resp_valid
- resp_err  out  1  qualifies resp_valid: illegal size or rejected misalign
- mem_rd  out  1  memory access strobe; high for loads AND stores
- mem_we  out  4  byte write enables
- mem_load_select  out  3  constant 3'b010
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  raw word; valid the cycle after the access cycle

Behaviour:
- States: IDLE, ACC0, ACC1, RESP.
- Reset values: state IDLE; req_ready 0 while rst is high; resp_valid 0; resp_err 0; resp_rdata 0; mem_rd 0; mem_we 0; mem_addr 0; mem_wdata 0.
- req_ready = (state==IDLE) & ~rst.
- IDLE:
  - Accept on req_valid & req_ready; latch we, funct3, addr, wdata.
  - Accept at cycle T.
- Size from funct3: n = 1/2/4 bytes. Offset o = addr[1:0]. Split when o+n > 4.
- Illegal funct3 is 011, 110, 111, or a store with funct3[2]=1. Illegal → RESP with resp_err=1; no mem_rd or mem_we issued.
- ACC0 (cycle T+1):
  - mem_rd=1; mem_addr = first word address.
  - Stores only: mem_we = low 4 bits of (((1<<n)-1)<<o); mem_wdata = low 32 bits of ({32'b0,wdata} << 8*o).
  - Loads: mem_we=0.
  - Next state is ACC1 if split, else RESP.
- ACC1 (T+2, split only):
  - mem_addr = first word address + 4, wrapping modulo 2^32.
  - mem_we = upper 4 bits of the mask; mem_wdata = upper 32 bits of the shifted data.
  - Captures mem_rdata (first word) into lo_q.
- RESP (T+2 unsplit, T+3 split):
  - resp_valid=1 for exactly one cycle; mem_rd=0; mem_we=0.
  - Loads: form 64-bit {hi,lo}: unsplit uses {32'b0, mem_rdata}; split uses {mem_rdata, lo_q}.
  - resp_rdata = the low n bytes of ({hi,lo} >> 8*o), sign-extended for B/H and zero-extended for BU/HU.
  - Stores: resp_rdata=0.
  - Next state IDLE.
- Throughput: one request per 3 cycles (unsplit) or 4 cycles (split).
- req_valid outside IDLE is ignored; the requester must hold the request until req_ready.
- No response backpressure.
- rst mid-operation: immediate return to IDLE. mem_rd and mem_we drop asynchronously. No resp_valid for the aborted request. Any half-done split store stays partially written.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: split behaviour as above. A misaligned access with addr[IO_SEL_BIT]=1 → resp_err, no memory access.
- Undefined: any access with o+n>4 goes IDLE→RESP with resp_err=1 and no memory access. ACC1 is unreachable and may be omitted.
- Aligned behaviour is identical in both builds.

Test Plan:
- SW addr 0x00000010, wdata 0xDEADBEEF → T+1: mem_we=4'b1111, mem_addr=0x10, mem_wdata=0xDEADBEEF; T+2: resp_valid=1, resp_err=0.
- LB addr 0x00000013, memory word 0x80FF1234 → mem_addr 0x10; resp_rdata=0xFFFFFF80. LBU from the same address → 0x00000080.
- SH addr 0x00000022, wdata 0x0000A55A → mem_we=4'b1100, mem_wdata=0xA55A0000, single access, resp at T+2.
- Split (EN defined):
  - LW addr 0x00000006; word 0x04 = 0x44332211, word 0x08 = 0x88776655.
  - ACC0 mem_addr 0x04, ACC1 mem_addr 0x08.
  - resp_rdata=0x66554433 at T+3.
  - SW 0xCAFEBABE to 0x07: mem_we 1000 then 0111; mem_wdata 0xBE000000 then 0x00CAFEBA.
- Misalign with EN undefined (LH addr 0x3), and funct3=3'b011 → resp_valid+resp_err at T+1; mem_rd never asserted.
- Assert rst during ACC1 of a split store → mem_we=0 in the same cycle, state IDLE, no resp_valid. After release, req_ready=1 and the next SW completes normally.
